// File: rtl/sram_row_fetcher_if.sv
// Command, SRAM-port and row-stream signals of the row fetcher.
// The master modport is the fetcher; the slave modport is the surrounding system.
interface sram_row_fetcher_if;
  logic        start;
  logic [9:0]  base_addr;
  logic [7:0]  num_rows;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  address;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] read_data;
  logic [1:0]  sram_state;
  logic [63:0] row_data;
  logic        row_valid;
  logic        row_ready;

  modport master (
    input  start, base_addr, num_rows, read_data, sram_state, row_ready,
    output busy, done, error, address, read_enable, write_enable, row_data, row_valid
  );

  modport slave (
    output start, base_addr, num_rows, read_data, sram_state, row_ready,
    input  busy, done, error, address, read_enable, write_enable, row_data, row_valid
  );
endinterface

// File: rtl/sram_row_fetcher.sv
// Streams num_rows 64-bit rows (two 32-bit SRAM words each) into a small output FIFO.
// A word completes on the first FREE cycle after request entry; ERROR aborts and flushes.
module sram_row_fetcher #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  sram_row_fetcher_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] SRAM_FREE  = 2'b00;
  localparam logic [1:0] SRAM_ERROR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, REQ_LO, REQ_HI, PUSH, DRAIN, DONE, ERR
  } state_t;

  state_t      state;
  logic [9:0]  addr_ctr;
  logic [7:0]  rows_left;
  logic [31:0] lo_reg;
  logic [31:0] hi_reg;
  logic        waited;
  logic        row_pending;

  logic [63:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic [AW:0]   count_nxt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign fifo_full  = (fifo_count == FIFO_FULL);
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !fifo_empty && bus.row_ready;
  // A push into a full FIFO is allowed when the consumer pops in the same cycle.
  assign push       = (state == PUSH) && row_pending && (!fifo_full || pop);
  assign count_nxt  = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

  assign bus.row_valid    = !fifo_empty;
  assign bus.row_data     = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign bus.write_enable = 1'b0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {hi_reg, lo_reg};
  end

  always_ff @(posedge clk) begin
    if (rst || state == ERR) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      addr_ctr        <= '0;
      rows_left       <= '0;
      lo_reg          <= '0;
      hi_reg          <= '0;
      waited          <= 1'b0;
      row_pending     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.address     <= '0;
      bus.read_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr_ctr    <= bus.base_addr;
            rows_left   <= bus.num_rows;
            bus.error   <= 1'b0;
            waited      <= 1'b0;
            row_pending <= 1'b0;
            if (bus.num_rows == 8'd0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else if (fifo_full) begin
              state    <= PUSH;
              bus.busy <= 1'b1;
            end else begin
              state           <= REQ_LO;
              bus.busy        <= 1'b1;
              bus.read_enable <= 1'b1;
              bus.address     <= bus.base_addr;
            end
          end
        end

        REQ_LO, REQ_HI: begin
          if (bus.sram_state == SRAM_ERROR) begin
            state           <= ERR;
            bus.read_enable <= 1'b0;
            bus.error       <= 1'b1;
          end else if (!waited) begin
            waited <= 1'b1;
          end else if (bus.sram_state == SRAM_FREE) begin
            waited   <= 1'b0;
            addr_ctr <= addr_ctr + 10'd1;
            if (state == REQ_LO) begin
              lo_reg      <= bus.read_data;
              bus.address <= addr_ctr + 10'd1;
              state       <= REQ_HI;
            end else begin
              hi_reg          <= bus.read_data;
              bus.read_enable <= 1'b0;
              row_pending     <= 1'b1;
              state           <= PUSH;
            end
          end
        end

        PUSH: begin
          // row_pending clear means we are holding off a full FIFO before the next row.
          if (row_pending) begin
            if (push) begin
              row_pending <= 1'b0;
              rows_left   <= rows_left - 8'd1;
              if (rows_left == 8'd1) begin
                state <= DRAIN;
              end else if (count_nxt != FIFO_FULL) begin
                state           <= REQ_LO;
                bus.read_enable <= 1'b1;
                bus.address     <= addr_ctr;
              end
            end
          end else if (!fifo_full) begin
            state           <= REQ_LO;
            bus.read_enable <= 1'b1;
            bus.address     <= addr_ctr;
          end
        end

        DRAIN: begin
          if (count_nxt == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        ERR: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_row_fetcher.md
# sram_row_fetcher

Bus-side read engine for the AI accelerator datapath. On a start command it streams `num_rows` 64-bit rows out of the 1024x32 SRAM wrapper, reading two consecutive 32-bit words per row, and presents them to the compute array over a valid/ready stream. A small output FIFO absorbs consumer back-pressure. The block honours the wrapper's `sram_state` wait/error signalling. It sits directly between the SRAM wrapper's port and the array's operand input, sharing the SRAM port under the top-level's mux.

## Interface
- FIFO_DEPTH, 2, output row FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle command pulse; ignored while busy
- base_addr  in  10  first SRAM word address, sampled with start
- num_rows  in  8  rows to fetch, sampled with start; 0 = no fetch
- busy  out  1  high from cycle after accepted start until done pulse
- done  out  1  one-cycle pulse when last row accepted by consumer (or immediately for num_rows=0)
- error  out  1  sticky; set on SRAM ERROR; cleared by rst or next accepted start
- address  out  10  SRAM word address
- read_enable  out  1  SRAM read request
- write_enable  out  1  constant 0
- read_data  in  32  SRAM read word
- sram_state  in  2  wrapper status: 2'b00 FREE, 2'b01 BUSY, 2'b10 ACCESS, 2'b11 ERROR
- row_data  out  64  FIFO head row, {hi_word, lo_word}
- row_valid  out  1  FIFO non-empty
- row_ready  in  1  consumer accepts head when row_valid && row_ready

## Operation
- States: IDLE, REQ_LO, REQ_HI, PUSH, DRAIN, DONE, ERR.
- IDLE: start=1 latches base_addr into addr_ctr and num_rows into rows_left, clears error.
  - num_rows=0 → DONE.
  - Otherwise → REQ_LO if the FIFO is not full, else wait in IDLE-equivalent hold (PUSH).
- REQ_LO / REQ_HI: drive address=addr_ctr and read_enable=1, holding both stable.
  - The read completes in the first cycle, at least one cycle after state entry, in which sram_state==FREE.
  - In that cycle, capture read_data into lo_reg/hi_reg and increment addr_ctr modulo 1024, so 1023 wraps to 0.
  - BUSY/ACCESS: hold request.
  - ERROR: → ERR.
- REQ_LO completion → REQ_HI. REQ_HI completion → PUSH.
- PUSH: write {hi_reg, lo_reg} to the FIFO and decrement rows_left.
  - rows_left now 0 → DRAIN.
  - Else FIFO full after write → stay in PUSH-wait (no read_enable) until not full.
  - Else → REQ_LO.
- DRAIN: wait until the FIFO is empty and the last row is accepted → DONE.
- DONE: done=1 for one cycle → IDLE.
- ERR: error=1, read_enable=0. Flush the FIFO, no done pulse → IDLE next cycle.
- read_enable is 0 in all states other than REQ_LO and REQ_HI. write_enable is always 0.
- A simultaneous FIFO push and consumer pop when full is legal. The occupancy count stays unchanged.
- start while busy: ignored, with no effect on counters.

## Timing
- Reset values: busy=0, done=0, error=0, address=0, read_enable=0, row_valid=0, row_data=0, FIFO empty, state IDLE.
- start sampled at edge N → busy=1 and read_enable=1 (address=base_addr) from cycle N+1.
- Zero-wait SRAM (FREE every cycle) gives 2 cycles per word, 5 cycles per row (LO, LO-done, HI, HI-done, PUSH).
  - First row_valid is 6 cycles after start with the consumer ready.
- Each BUSY/ACCESS cycle on sram_state extends the current word by one cycle.
- Row order equals address order. Lo word is at the even offset from base, hi word at the next address.
- done asserts the cycle after the final handshake. busy drops in the same cycle done rises.
- rst mid-operation: all state, counters and FIFO cleared at the next edge. No done pulse. read_enable=0 the following cycle.

## Test plan
- Reset then idle: all outputs 0 and read_enable never asserted for 20 cycles.
- base_addr=0x010, num_rows=3, SRAM[0x10..0x15]=0x11..0x66, row_ready=1, zero-wait → rows 0x00000022_00000011, 0x00000044_00000033, 0x00000066_00000055 in order; done exactly once; busy 0 afterwards.
- Same transfer with row_ready=0 for 30 cycles → FIFO holds FIFO_DEPTH rows, read_enable stays 0 while full; release row_ready → remaining row delivered, no loss or duplication.
- base_addr=0x3FE, num_rows=2 → reads 0x3FE, 0x3FF, 0x000, 0x001 (wrap); row order correct.
- sram_state=BUSY for 3 cycles per word → address and read_enable stable throughout; total latency grows by 3 per word; data correct.
- sram_state=ERROR during the 2nd row → error=1 sticky, FIFO flushed, no done; a new start clears error and completes normally. num_rows=0 → done the cycle after start, no SRAM access.
